// File: rtl/narnet_seq_driver.sv
// NAR-Net sequence driver: feeds buffered or fed-back samples to the network one at a time
// and returns each prediction on a valid/ready result stream, with timeout and network reset control.
module narnet_seq_driver #(
    parameter int N       = 10,
    parameter int Q       = 9,
    parameter int DEPTH   = 64,
    parameter int AW      = 6,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    input  logic          start,
    input  logic          mode,
    input  logic [AW:0]   num,
    input  logic [AW-1:0] prime,
    output logic          net_enable,
    output logic          net_rst,
    output logic [N-1:0]  x_out,
    output logic          x_ready,
    input  logic [N-1:0]  y_in,
    input  logic          out_ready,
    output logic          res_valid,
    output logic [N-1:0]  res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    state_dbg
);

    // Result stream: a word transfers on a rising edge where res_valid && res_ready;
    // res_valid and res_data stay stable until that transfer.

    typedef enum logic [2:0] {
        S_IDLE, S_NRST, S_ISSUE, S_WAIT, S_STORE, S_FIN, S_ERR
    } state_t;

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   IDX_MAX = AW'(DEPTH - 1);
    localparam logic [AW:0]     NUM_MAX = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);

    if (Q >= N || (1 << AW) < DEPTH) begin : g_bad_params
        $error("narnet_seq_driver: invalid parameter set");
    end

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] issue_idx;
    logic [AW-1:0] prime_q;
    logic [AW:0]   num_q;
    logic [AW:0]   cnt;
    logic          mode_q;
    logic          nrst_cnt;
    logic [TW-1:0] timer;
    logic [N-1:0]  y_reg;
    logic [N-1:0]  issue_x;
    logic          seed_sel;

    assign state_dbg = state;

    // The next issued sample is chosen one cycle early so x_out is registered with x_ready.
    // A prime of 0 stands for a full buffer of seeds (DEPTH does not fit in AW bits).
    always_comb begin
        idx_inc   = (idx == IDX_MAX) ? idx : idx + 1'b1;
        issue_idx = (state == S_STORE) ? idx_inc : idx;
        seed_sel  = !mode_q || (prime_q == '0) || (issue_idx < prime_q);
        issue_x   = seed_sel ? mem[issue_idx] : y_reg;
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && ld_valid) begin
            mem[wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            idx        <= '0;
            cnt        <= '0;
            num_q      <= '0;
            prime_q    <= '0;
            mode_q     <= 1'b0;
            nrst_cnt   <= 1'b0;
            timer      <= '0;
            y_reg      <= '0;
            net_enable <= 1'b0;
            net_rst    <= 1'b1;
            x_out      <= '0;
            x_ready    <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            net_enable <= 1'b1;
            done       <= 1'b0;
            x_ready    <= 1'b0;
            case (state)
                S_IDLE: begin
                    net_rst   <= 1'b0;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    if (ld_valid) begin
                        wptr <= (wptr == IDX_MAX) ? '0 : wptr + 1'b1;
                    end
                    // Same-cycle load lands at the old pointer; the clear below overrides the increment.
                    if (start) begin
                        wptr    <= '0;
                        mode_q  <= mode;
                        num_q   <= (num > NUM_MAX) ? NUM_MAX : num;
                        prime_q <= prime;
                        err     <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                        if (num == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= S_NRST;
                            net_rst  <= 1'b1;
                            busy     <= 1'b1;
                            nrst_cnt <= 1'b0;
                        end
                    end
                end
                S_NRST: begin
                    if (nrst_cnt) begin
                        state   <= S_ISSUE;
                        net_rst <= 1'b0;
                        x_ready <= 1'b1;
                        x_out   <= issue_x;
                    end else begin
                        nrst_cnt <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // timer counts cycles since the strobe, so the registered err lands TIMEOUT cycles after x_ready
                    state <= S_WAIT;
                    timer <= TW'(1);
                end
                S_WAIT: begin
                    if (out_ready) begin
                        y_reg     <= y_in;
                        res_data  <= y_in;
                        res_valid <= 1'b1;
                        state     <= S_STORE;
                    end else if (timer >= T_LAST) begin
                        err     <= 1'b1;
                        net_rst <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STORE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cnt       <= cnt + 1'b1;
                        idx       <= idx_inc;
                        if (cnt + 1'b1 == num_q) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_ISSUE;
                            x_ready <= 1'b1;
                            x_out   <= issue_x;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_ERR: begin
                    state   <= S_IDLE;
                    net_rst <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
